mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle main control FSM.
- Consumes the FSM's memory-access controls (iord, irwrite, memwrite, request strobe) and runs one access on a shared instruction/data memory using a req/ack handshake.
- Latches fetched instructions into the instruction register (IR) and load data into the memory data register (MDR).
- Reports completion, misalignment and timeout back to the FSM so it can stall in fetch, MemRead and MemWrite.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting. Legal range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  in  1  single-cycle access request from the control FSM.
- iord  in  1  address select: 0 selects pc, 1 selects aluout.
- irwrite  in  1  read result goes to IR (instruction fetch).
- memwrite  in  1  1 means write access, 0 means read access.
- pc  in  AW  program counter.
- aluout  in  AW  ALU output register (data address).
- wdata  in  DW  store data (register B).
- ready  out  1  unit is idle and will accept mem_req.
- done  out  1  one-cycle pulse when an access completes successfully.
- err  out  1  one-cycle pulse on misaligned address or timeout.
- instr  out  DW  IR contents.
- mdr  out  DW  MDR contents.
- bus_req  out  1  memory request; held until ack or abort.
- bus_we  out  1  memory write enable.
- bus_addr  out  AW  memory address.
- bus_wdata  out  DW  memory write data.
- bus_rdata  in  DW  memory read data; valid when bus_ack=1.
- bus_ack  in  1  memory acknowledge.

Behaviour:
- Reset (asynchronous, immediate):
  - State becomes IDLE; instr, mdr, bus_addr, bus_wdata and the timeout counter clear to 0.
  - bus_req, bus_we, done and err become 0; ready becomes 1.
  - Reset during BUS abandons the access with no IR/MDR update and no done or err pulse.
- States are IDLE, BUS and RESP.
- IDLE:
  - ready=1.
  - When mem_req=1 and the selected address has bits [1:0]=0:
    - Latch bus_addr (iord ? aluout : pc), bus_wdata=wdata, bus_we=memwrite, and the irwrite flag.
    - Clear the counter, set bus_req=1 and go to BUS.
  - When mem_req=1 and the address is misaligned: err=1 on the next cycle, no bus activity, stay in IDLE.
- BUS:
  - ready=0 and bus_req=1; bus_addr, bus_we and bus_wdata are held stable.
  - On bus_ack=1:
    - Drop bus_req and go to RESP.
    - For a read with irwrite latched, instr<=bus_rdata at this edge.
    - For a read without irwrite, mdr<=bus_rdata.
    - A write updates neither register.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack, the unit drops bus_req, pulses err for one cycle and returns to IDLE.
  - An ack arriving in the same cycle as the final count takes priority, so the access completes normally.
- RESP:
  - done=1 for exactly one cycle; ready=0.
  - The unit returns to IDLE next cycle.
- Latency:
  - mem_req is sampled at edge N, and bus_req is high from N to N+1.
  - With a zero-wait memory (ack in the first BUS cycle), done is high in cycle N+2 and ready is high again at N+3.
  - Each wait cycle adds one cycle.
- Requests and inputs while busy:
  - mem_req while ready=0 is ignored (not queued). The FSM must hold in its state until done or err.
  - Changes to pc, aluout, wdata or the control inputs during BUS or RESP have no effect.
- instr and mdr hold their value indefinitely between updates.
- bus_ack while in IDLE or RESP is ignored.
- When both irwrite=1 and memwrite=1, the access is a write and instr is not updated.

Test Plan:
- Fetch, zero wait:
  - Stimulus: pc=0x00000040, iord=0, irwrite=1, mem_req pulse; memory acks in the first BUS cycle with rdata=0x8C080004.
  - Required: bus_addr=0x40, bus_we=0; instr=0x8C080004 and done=1 exactly 2 cycles after mem_req; mdr unchanged.
- Load with 3 wait states:
  - Stimulus: aluout=0x00000104, iord=1, irwrite=0; rdata=0xDEADBEEF.
  - Required: bus_req high for 4 cycles; mdr=0xDEADBEEF; done 5 cycles after mem_req; instr unchanged.
- Store:
  - Stimulus: aluout=0x00000200, wdata=0x12345678, memwrite=1.
  - Required: bus_we=1 and bus_wdata=0x12345678 held until ack; done pulses once; instr and mdr unchanged.
- Misaligned and timeout:
  - Misaligned: aluout=0x00000102, iord=1. Required: err pulse next cycle, bus_req never asserted.
  - Timeout: TIMEOUT=4 and no ack. Required: bus_req high 4 cycles, then err pulse, then ready=1 and no done.
- Reset mid-access and busy-ignore:
  - Stimulus: assert rst_n=0 during BUS, then release; separately pulse mem_req during BUS.
  - Required on reset: bus_req=0, instr=0, mdr=0, ready=1 immediately (asynchronous).
  - Required on busy-ignore: the second request produces no extra bus access.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : runs one req/ack access per FSM request, loads IR or MDR
// Rev 1.0
// ============================================================================
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_req,
  input  logic          iord,
  input  logic          irwrite,
  input  logic          memwrite,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] mdr,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [15:0] c_LAST = 16'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_cnt;
  logic          r_irw;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] r_mdr;

  logic [AW-1:0] w_addr_sel;
  logic          w_aligned;
  logic          w_start;
  logic          w_misal;
  logic          w_timeout;
  logic          w_rd_ack;

  assign w_addr_sel = iord ? aluout : pc;
  assign w_aligned  = (w_addr_sel[1:0] == 2'b00);
  assign w_start    = (r_state == S_IDLE) && mem_req && w_aligned;
  assign w_misal    = (r_state == S_IDLE) && mem_req && !w_aligned;
  // An ack on the final count wins over the timeout.
  assign w_timeout  = (r_state == S_BUS) && !bus_ack && (r_cnt == c_LAST);
  assign w_rd_ack   = (r_state == S_BUS) && bus_ack && !r_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_BUS;
      S_BUS: begin
        if (bus_ack)        w_next = S_RESP;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_irw   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_instr <= '0;
      r_mdr   <= '0;
    end else begin
      r_err <= w_misal | w_timeout;
      if (w_start) begin
        r_addr  <= w_addr_sel;
        r_wdata <= wdata;
        r_we    <= memwrite;
        r_irw   <= irwrite;
        r_cnt   <= '0;
      end else if ((r_state == S_BUS) && !bus_ack) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_rd_ack) begin
        if (r_irw) r_instr <= bus_rdata;
        else       r_mdr   <= bus_rdata;
      end
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_RESP);
  assign bus_req   = (r_state == S_BUS);
  assign err       = r_err;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign instr     = r_instr;
  assign mdr       = r_mdr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : randomized accesses against a transaction-level model
// Rev 1.0
// ============================================================================
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req = 1'b0;
  logic          iord = 1'b0;
  logic          irwrite = 1'b0;
  logic          memwrite = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] aluout = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready;
  logic          done;
  logic          err;
  logic [DW-1:0] instr;
  logic [DW-1:0] mdr;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] m_instr = '0;
  logic [DW-1:0] m_mdr   = '0;

  mem_access_unit #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .iord      (iord),
    .irwrite   (irwrite),
    .memwrite  (memwrite),
    .pc        (pc),
    .aluout    (aluout),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .instr     (instr),
    .mdr       (mdr),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, "_instr"}, 64'(instr), 64'(m_instr));
    check_val({tag, "_mdr"},   64'(mdr),   64'(m_mdr));
  endtask

  // One FSM request; the memory acks after 'waits' stall cycles (never if waits >= TO).
  task automatic do_access(input logic io, input logic irw, input logic mw,
                           input logic [AW-1:0] pcv, input logic [AW-1:0] aluv,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                           input int waits);
    logic [AW-1:0] ea;
    logic          tmo;
    int            nb;
    int            exp_nb;
    ea = io ? aluv : pcv;
    iord = io; irwrite = irw; memwrite = mw;
    pc = pcv; aluout = aluv; wdata = wd; mem_req = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0;
    if (ea[1:0] != 2'b00) begin
      check_val("misal_err",   64'(err),     64'd1);
      check_val("misal_noreq", 64'(bus_req), 64'd0);
      check_val("misal_ready", 64'(ready),   64'd1);
      @(posedge clk); #1;
      check_val("misal_err_clr", 64'(err),     64'd0);
      check_val("misal_noreq2",  64'(bus_req), 64'd0);
      check_regs("misal");
      return;
    end
    tmo    = (waits >= TO);
    exp_nb = tmo ? TO : waits + 1;
    nb     = 0;
    while (bus_req === 1'b1 && nb < 64) begin
      check_val("bus_addr",  64'(bus_addr),  64'(ea));
      check_val("bus_we",    64'(bus_we),    64'(mw));
      if (mw) check_val("bus_wdata", 64'(bus_wdata), 64'(wd));
      check_val("busy_ready", 64'(ready), 64'd0);
      bus_ack   = (nb == waits);
      bus_rdata = (nb == waits) ? rd : DW'($urandom);
      // Scramble inputs and throw stray requests while busy.
      pc = AW'($urandom); aluout = AW'($urandom); wdata = DW'($urandom);
      iord = 1'($urandom); irwrite = 1'($urandom); memwrite = 1'($urandom);
      mem_req = 1'($urandom);
      @(posedge clk); #1;
      bus_ack = 1'b0; mem_req = 1'b0;
      nb++;
    end
    check_val("bus_cycles", 64'(nb), 64'(exp_nb));
    if (!tmo) begin
      if (!mw) begin
        if (irw) m_instr = rd;
        else     m_mdr   = rd;
      end
      check_val("done",       64'(done),  64'd1);
      check_val("done_noerr", 64'(err),   64'd0);
      check_val("resp_ready", 64'(ready), 64'd0);
      check_regs("resp");
      bus_ack = 1'b1; bus_rdata = DW'($urandom); mem_req = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0; mem_req = 1'b0;
      check_val("done_clr",   64'(done),    64'd0);
      check_val("idle_ready", 64'(ready),   64'd1);
      check_val("idle_noreq", 64'(bus_req), 64'd0);
      check_regs("idle");
    end else begin
      check_val("tmo_err",    64'(err),   64'd1);
      check_val("tmo_nodone", 64'(done),  64'd0);
      check_val("tmo_ready",  64'(ready), 64'd1);
      check_regs("tmo");
      @(posedge clk); #1;
      check_val("tmo_err_clr", 64'(err),     64'd0);
      check_val("tmo_noreq",   64'(bus_req), 64'd0);
      check_val("tmo_nodone2", 64'(done),    64'd0);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    #1;
    check_val("rst_ready",   64'(ready),    64'd1);
    check_val("rst_bus_req", 64'(bus_req),  64'd0);
    check_val("rst_done",    64'(done),     64'd0);
    check_val("rst_err",     64'(err),      64'd0);
    check_val("rst_addr",    64'(bus_addr), 64'd0);
    check_regs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h8C08_0004, 0);
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
    do_access(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_FFFF, 2);
    do_access(1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 32'hCAFE_0001, 32'h5555_AAAA, 1);
    do_access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0102, 32'h0, 32'h0, 0);
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0, 32'h0, 100);

    // Asynchronous reset in the middle of a read.
    iord = 1'b1; irwrite = 1'b0; memwrite = 1'b0; aluout = 32'h0000_0400; mem_req = 1'b1;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    m_instr = '0; m_mdr = '0;
    check_val("arst_bus_req", 64'(bus_req), 64'd0);
    check_val("arst_ready",   64'(ready),   64'd1);
    check_val("arst_done",    64'(done),    64'd0);
    check_regs("arst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("arst_noerr", 64'(err), 64'd0);

    for (int i = 0; i < 150; i++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if (1'($urandom)) do_access(1'b1, 1'($urandom), 1'($urandom), AW'($urandom) & ~32'h3, a,
                                  DW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 1)));
      else              do_access(1'b0, 1'($urandom), 1'($urandom), a, AW'($urandom),
                                  DW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
